// File: rtl/alu_pkg.sv
// Shared encodings for the arbitrated ALU: control codes,
// sequencer states and the default datapath width.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two request ports plus one tagged response channel.
// master: requesters and result consumer; slave: the arbiter.
interface alu_arbiter_if #(
    parameter int N = 32
);

    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_ctrl;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_ctrl;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational N-bit ALU: add/sub/and/or/slt.
// Unknown control codes yield zero so a response is still produced.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   ctrl_i,
    output logic [N-1:0] result_o,
    output logic         zero_o
);

    logic [N-1:0] sum;
    logic [N-1:0] b_op;
    logic         sub;
    logic         lt;

    assign sub  = (ctrl_i == ALU_SUB);
    assign b_op = sub ? ~b_i : b_i;
    assign sum  = a_i + b_op + {{(N-1){1'b0}}, sub};
    assign lt   = $signed(a_i) < $signed(b_i);

    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_ADD: result_o = sum;
            ALU_SUB: result_o = sum;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_SLT: result_o = {{(N-1){1'b0}}, lt};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters,
// one op in flight, registered operands and tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input logic          clk,
    input logic          reset,
    alu_arbiter_if.slave bus
);

    state_e       state_q, state_d;
    logic         prio_q, prio_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [2:0]   ctrl_q, ctrl_d;
    logic         id_q, id_d;
    logic [N-1:0] res_q, res_d;
    logic         zero_q, zero_d;
    logic         rid_q, rid_d;

    logic         any_v;
    logic         gnt_id;
    logic [N-1:0] alu_res;
    logic         alu_zero;

    // Contention goes to prio; otherwise the lone valid port wins.
    assign any_v  = bus.req0_valid | bus.req1_valid;
    assign gnt_id = (bus.req0_valid & bus.req1_valid)
                  ? prio_q : bus.req1_valid;

    alu_arbiter_alu #(.N(N)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .ctrl_i   (ctrl_q),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        a_d            = a_q;
        b_d            = b_q;
        ctrl_d         = ctrl_q;
        id_d           = id_q;
        res_d          = res_q;
        zero_d         = zero_q;
        rid_d          = rid_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_v) begin
                    bus.req0_ready = ~gnt_id;
                    bus.req1_ready = gnt_id;
                    a_d     = gnt_id ? bus.req1_a : bus.req0_a;
                    b_d     = gnt_id ? bus.req1_b : bus.req0_b;
                    ctrl_d  = gnt_id ? bus.req1_ctrl : bus.req0_ctrl;
                    id_d    = gnt_id;
                    prio_d  = ~gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                rid_d   = id_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            rid_q   <= rid_d;
        end
    end

    // Response fields read as zero whenever no result is offered.
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_id     = bus.rsp_valid & rid_q;
    assign bus.rsp_zero   = bus.rsp_valid & zero_q;
    assign bus.rsp_result = bus.rsp_valid ? res_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant timing, round-robin,
// backpressure, edge arithmetic, async reset and idle behaviour.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    rsp_t sb[$];

    alu_arbiter_if #(.N(32)) bus ();

    alu_arbiter #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_rsp(input string tag);
        rsp_t e;
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"}, bus.rsp_id, e.id);
            chk({tag, "_res"}, bus.rsp_result, e.res);
            chk({tag, "_zero"}, bus.rsp_zero, e.zero);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_r0"}, bus.req0_ready, 0);
        chk({tag, "_r1"}, bus.req1_ready, 0);
        chk({tag, "_v"}, bus.rsp_valid, 0);
        chk({tag, "_id"}, bus.rsp_id, 0);
        chk({tag, "_res"}, bus.rsp_result, 0);
        chk({tag, "_z"}, bus.rsp_zero, 0);
    endtask

    task automatic drive(input logic port, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] ctrl);
        if (port) begin
            bus.req1_valid = 1'b1;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_ctrl  = ctrl;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_ctrl  = ctrl;
        end
    endtask

    task automatic drop();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic port,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] ctrl,
                          input logic [31:0] res, input logic zero);
        drive(port, a, b, ctrl);
        #1;
        chk({tag, "_g0"}, bus.req0_ready, {31'd0, ~port});
        chk({tag, "_g1"}, bus.req1_ready, {31'd0, port});
        sb.push_back(rsp_t'{port, res, zero});
        tick();
        drop();
        #1;
        chk({tag, "_exec_v"}, bus.rsp_valid, 0);
        tick();
        chk_rsp(tag);
        tick();
        chk({tag, "_idle_v"}, bus.rsp_valid, 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req0_a    = '0;
        bus.req0_b    = '0;
        bus.req0_ctrl = '0;
        bus.req1_a    = '0;
        bus.req1_b    = '0;
        bus.req1_ctrl = '0;
        drop();
        repeat (2) @(negedge clk);
        chk_outs_zero("reset");
        reset = 1'b0;
        #1;

        // Contention from reset: port 0 first, then port 1, then port 0.
        drive(0, 32'd5, 32'd3, ALU_ADD);
        drive(1, 32'd5, 32'd5, ALU_SUB);
        #1;
        chk("c1_g0", bus.req0_ready, 1);
        chk("c1_g1", bus.req1_ready, 0);
        sb.push_back(rsp_t'{1'b0, 32'd8, 1'b0});
        tick();
        chk("c1_exec_r0", bus.req0_ready, 0);
        chk("c1_exec_r1", bus.req1_ready, 0);
        chk("c1_exec_v", bus.rsp_valid, 0);
        tick();
        chk_rsp("c1");
        chk("c1_done_r0", bus.req0_ready, 0);
        chk("c1_done_r1", bus.req1_ready, 0);
        tick();
        chk("c2_g0", bus.req0_ready, 0);
        chk("c2_g1", bus.req1_ready, 1);
        sb.push_back(rsp_t'{1'b1, 32'd0, 1'b1});
        tick();
        tick();
        chk_rsp("c2");
        tick();
        chk("c3_g0", bus.req0_ready, 1);
        chk("c3_g1", bus.req1_ready, 0);
        sb.push_back(rsp_t'{1'b0, 32'd8, 1'b0});
        tick();
        drop();
        tick();
        chk_rsp("c3");
        tick();

        run_op("single_or", 0, 32'h0000_000F, 32'h0000_005A, ALU_OR,
               32'h0000_005F, 0);

        // Backpressure: response held while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        drive(1, 32'h0000_0F0F, 32'h0000_00FF, ALU_AND);
        #1;
        chk("bp_g1", bus.req1_ready, 1);
        sb.push_back(rsp_t'{1'b1, 32'h0000_000F, 1'b0});
        tick();
        drive(0, 32'd1, 32'd2, ALU_ADD);
        #1;
        chk("bp_exec_r0", bus.req0_ready, 0);
        chk("bp_exec_r1", bus.req1_ready, 0);
        tick();
        chk_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_v", bus.rsp_valid, 1);
            chk("bp_hold_res", bus.rsp_result, 32'h0000_000F);
            chk("bp_hold_id", bus.rsp_id, 1);
            chk("bp_hold_z", bus.rsp_zero, 0);
            chk("bp_hold_r0", bus.req0_ready, 0);
            chk("bp_hold_r1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_rel_r0", bus.req0_ready, 0);
        chk("bp_rel_r1", bus.req1_ready, 0);
        tick();
        chk("bp_next_g0", bus.req0_ready, 1);
        chk("bp_next_g1", bus.req1_ready, 0);
        sb.push_back(rsp_t'{1'b0, 32'd3, 1'b0});
        tick();
        drop();
        tick();
        chk_rsp("bp_next");
        tick();

        run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'h1, ALU_ADD, 32'h0, 1);
        run_op("slt_neg", 1, 32'h8000_0000, 32'h1, ALU_SLT, 32'h1, 0);
        run_op("slt_pos", 0, 32'h1, 32'h8000_0000, ALU_SLT, 32'h0, 1);
        run_op("illegal", 1, 32'h1234, 32'h5678, 3'b111, 32'h0, 1);
        run_op("sub", 0, 32'd7, 32'd3, ALU_SUB, 32'd4, 0);

        // Async reset while a result waits in DONE.
        bus.rsp_ready = 1'b0;
        drive(0, 32'h0000_00A0, 32'h0000_0005, ALU_OR);
        #1;
        chk("rst_g0", bus.req0_ready, 1);
        tick();
        drop();
        tick();
        chk("rst_done_v", bus.rsp_valid, 1);
        chk("rst_done_res", bus.rsp_result, 32'h0000_00A5);
        reset = 1'b1;
        #1;
        chk_outs_zero("rst_async");
        tick();
        chk_outs_zero("rst_held");
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        drive(0, 32'd10, 32'd20, ALU_ADD);
        drive(1, 32'd1, 32'd2, ALU_OR);
        #1;
        chk("rst_rel_g0", bus.req0_ready, 1);
        chk("rst_rel_g1", bus.req1_ready, 0);
        sb.push_back(rsp_t'{1'b0, 32'd30, 1'b0});
        tick();
        drop();
        #1;
        chk("rst_rel_exec_v", bus.rsp_valid, 0);
        tick();
        chk_rsp("rst_rel");
        tick();

        // Idle stretch must not disturb prio (port 1 next).
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_outs_zero("idle");
        end
        drive(0, 32'd1, 32'd1, ALU_ADD);
        drive(1, 32'd2, 32'd2, ALU_ADD);
        #1;
        chk("idle_g0", bus.req0_ready, 0);
        chk("idle_g1", bus.req1_ready, 1);
        sb.push_back(rsp_t'{1'b1, 32'd4, 1'b0});
        tick();
        drop();
        tick();
        chk_rsp("idle_after");
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters (port 0: instruction datapath, port 1: debug/test port) on the RISC-V core. Round-robin arbitration, valid/ready request handshake per port, registered operands and result, single response channel tagged with the requester ID. Sequencing is a 3-state FSM, one operation in flight at a time.

## Interface
- N, 32: operand and result width in bits.
- clk  in  1  clock, rising-edge active.
- reset  in  1  asynchronous, active-high. Clears FSM, registers and priority pointer.
- req0_valid, req1_valid  in  1 each  request present on port 0 / port 1.
- req0_ready, req1_ready  out  1 each  request accepted this cycle (grant).
- req0_a, req0_b, req1_a, req1_b  in  N each  operands.
- req0_ctrl, req1_ctrl  in  3 each  ALU control: 000 add, 001 sub, 010 and, 011 or, 101 slt. Other codes are illegal.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  N  ALU result.
- rsp_zero  out  1  rsp_result == 0.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state IDLE.
- IDLE: if any reqX_valid, grant exactly one: reqX_ready=1 combinationally that cycle; latch a, b, ctrl, id into operand registers; go to EXEC. No valid: stay IDLE.
- Arbitration: 1-bit priority pointer prio, reset 0. One requester valid: it wins. Both valid: port prio wins. After each grant, prio = ~granted_id.
- EXEC: ALU evaluates latched operands; result, zero and id captured into response registers; go to DONE.
- DONE: rsp_valid=1; outputs stable until handshake. rsp_valid & rsp_ready: go to IDLE. No new grant in EXEC or DONE (reqX_ready=0).
- Arithmetic: add/sub modulo 2^N, carry dropped; slt signed two's complement, result 1 or 0 zero-extended; and/or bitwise. Illegal ctrl: rsp_result=0, rsp_zero=1, still returns a response.
- Reset mid-operation (EXEC or DONE): op dropped, no response, IDLE next, prio=0.
- Requester may change or drop valid while not granted; no effect on state.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
- Grant in cycle T (IDLE); EXEC in T+1; rsp_valid first high in T+2.
- rsp_ready already high in T+2: back in IDLE at T+3; next grant possible T+3. Peak throughput: 1 op / 3 cycles.
- rsp_ready low: DONE held indefinitely, rsp_* constant.
- Ready signals depend combinationally on valid and state only, never on rsp_ready.

## Structure
- Shared package alu_pkg: ALU control encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), FSM state encodings for IDLE/EXEC/DONE.
- One sub-module: alu (combinational, N-bit, inputs a, b, ctrl; outputs result, zero), built from the existing bitwise gate blocks (orN etc.) plus adder. Arbiter holds FSM, prio, operand and response registers.

## Test plan
- Single op: port 0 or, a=0x0000000F, b=0x0000005A, rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, rsp_result=0x0000005F, rsp_id=0, rsp_zero=0.
- Contention: both valid from reset, port 0 add 5+3, port 1 sub 5-5 -> port 0 first (result 8, id 0), then port 1 (result 0, zero=1, id 1); third contended grant goes to port 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* unchanged, both ready low; rsp_ready=1 -> IDLE next cycle, next grant one cycle later.
- Edge arithmetic: add 0xFFFFFFFF+1 -> 0, zero=1; slt 0x80000000 vs 0x00000001 -> 1; slt 1 vs 0x80000000 -> 0; illegal ctrl 111 -> 0, zero=1.
- Reset in DONE with rsp_valid=1 -> all outputs 0 immediately (async); no response after release; first grant after release goes to port 0 when both valid.
- Idle: no valid for 10 cycles -> state IDLE, all outputs 0, prio unchanged.
